// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, operation encoding and FSM state type for
// muldiv_sequencer and its sub-modules.
package muldiv_pkg;

   localparam int WIDTH     = 32;
   localparam int DIV_STEPS = 32;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // Quotient reported for a divide by zero (all ones, as -1 / unsigned max).
   localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_HOLD,
      S_DIV_ITER,
      S_DIV_FIX,
      S_DONE
   } state_t;

   // Two's-complement magnitude; the most negative value maps to its own
   // bit pattern, which read as unsigned is the correct magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/booth_multiplier.sv
// booth_multiplier: combinational radix-2 Booth signed multiplier producing
// the full 2*WIDTH-bit product. Used as a multicycle path by the sequencer.
module booth_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product
);

   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] acc;
   logic               prev;

   assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};

   // Accumulate +/- shifted multiplicand for every Booth bit pair of b.
   always_comb begin
      // NOTE: acc and prev get a value before the loop so no path leaves them
      // unassigned (no latch); blocking '=' is right here because each loop
      // iteration reads the value the previous one just wrote.
      acc  = '0;
      prev = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         case ({b[i], prev})
            2'b01:   acc = acc + (a_ext << i);
            2'b10:   acc = acc - (a_ext << i);
            default: ;
         endcase
         prev = b[i];
      end
   end

   assign product = acc;

endmodule

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring-division step. Shifts the next dividend bit
// into the partial remainder, trial-subtracts the divisor on 33 bits and
// shifts the resulting quotient bit into q.
module muldiv_div_step
   import muldiv_pkg::*;
(
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   assign shifted = {rem, q[WIDTH-1]};
   assign trial   = shifted - {1'b0, divisor};

   // A set sign bit means the divisor did not fit: restore the shifted value.
   assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign q_next   = {q[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle signed MUL/DIV unit for the HI/LO path.
// MUL holds registered operands on booth_multiplier for MUL_WAIT cycles,
// DIV runs a one-bit-per-cycle restoring divider on magnitudes and fixes
// signs at the end. Define MULDIV_EARLY_OUT_EN to finish trivial MUL
// (zero operand) and DIV (|a| < |b|) operations in a single cycle.
module muldiv_sequencer #(
   parameter int WIDTH    = 32,   // only 32 is supported
   parameter int MUL_WAIT = 2     // must be >= 1
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_by_zero
);

   import muldiv_pkg::*;

   localparam int CNT_W = ($clog2(MUL_WAIT) > $clog2(DIV_STEPS)) ?
                          $clog2(MUL_WAIT) : $clog2(DIV_STEPS);
   localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_WAIT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_STEPS - 1);

   state_t             state;
   state_t             next_state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   div_rem;
   logic [WIDTH-1:0]   div_q;
   logic [WIDTH-1:0]   div_rem_next;
   logic [WIDTH-1:0]   div_q_next;
   logic [2*WIDTH-1:0] product;
   logic               accept;
   logic               div_zero;
   logic               mul_early;
   logic               div_early;
   logic               q_neg;
   logic               r_neg;

   assign accept   = (state == S_IDLE) && start;
   assign div_zero = (b_in == '0);

`ifdef MULDIV_EARLY_OUT_EN
   assign mul_early = (a_in == '0) || (b_in == '0);
   assign div_early = magnitude(a_in) < magnitude(b_in);
`else
   assign mul_early = 1'b0;
   assign div_early = 1'b0;
`endif

   // Sign handling: quotient negative when signs differ, remainder follows a.
   assign b_mag = magnitude(b_reg);
   assign q_neg = a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
   assign r_neg = a_reg[WIDTH-1];

   booth_multiplier #(.WIDTH(WIDTH)) u_mul (
      .a       (a_reg),
      .b       (b_reg),
      .product (product)
   );

   muldiv_div_step u_div_step (
      .rem      (div_rem),
      .q        (div_q),
      .divisor  (b_mag),
      .rem_next (div_rem_next),
      .q_next   (div_q_next)
   );

   // State register; clear forces IDLE and thereby drops any operation.
   always_ff @(posedge clock) begin
      // NOTE: state is written with '<=' so every flop samples pre-edge values.
      if (clear) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state decode plus busy/done, all derived from the current state.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MUL) next_state = mul_early ? S_DONE : S_MUL_HOLD;
               else              next_state = (div_zero || div_early) ? S_DONE : S_DIV_ITER;
            end
         end
         S_MUL_HOLD: begin
            busy = 1'b1;
            if (cnt == '0) next_state = S_DONE;
         end
         S_DIV_ITER: begin
            busy = 1'b1;
            if (cnt == '0) next_state = S_DIV_FIX;
         end
         S_DIV_FIX: begin
            busy       = 1'b1;
            next_state = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Operand capture, step counter and divider working registers.
   always_ff @(posedge clock) begin
      // NOTE: no reset on these: an accepted start always loads them before
      // any state reads them, and clear already stops them being consumed.
      if (accept) begin
         a_reg   <= a_in;
         b_reg   <= b_in;
         cnt     <= (op == OP_MUL) ? MUL_CNT_INIT : DIV_CNT_INIT;
         div_rem <= '0;
         div_q   <= magnitude(a_in);
      end else if (state == S_MUL_HOLD) begin
         cnt <= cnt - 1'b1;
      end else if (state == S_DIV_ITER) begin
         cnt     <= cnt - 1'b1;
         div_rem <= div_rem_next;
         div_q   <= div_q_next;
      end
   end

   // Architectural results: only final values are ever written here.
   always_ff @(posedge clock) begin
      if (clear) begin
         hi_out      <= '0;
         lo_out      <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         div_by_zero <= 1'b0;
         if (op == OP_DIV && div_zero) begin
            lo_out      <= DIV_ZERO_QUOT;
            hi_out      <= a_in;
            div_by_zero <= 1'b1;
         end else if (op == OP_DIV && div_early) begin
            lo_out <= '0;
            hi_out <= a_in;
         end else if (op == OP_MUL && mul_early) begin
            lo_out <= '0;
            hi_out <= '0;
         end
      end else if (state == S_MUL_HOLD && cnt == '0) begin
         {hi_out, lo_out} <= product;
      end else if (state == S_DIV_FIX) begin
         lo_out <= q_neg ? -div_q : div_q;
         hi_out <= r_neg ? -div_rem : div_rem;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer. The driver
// pushes the expected result and done cycle for every accepted operation;
// a negedge monitor pops and compares on each done pulse and checks that
// HI/LO hold while busy. Honours MULDIV_EARLY_OUT_EN when defined.
module tb_muldiv_sequencer;

   localparam int MUL_WAIT = 2;
   localparam int DIV_LAT  = 34;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          cyc;
   } exp_t;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        start = 1'b0;
   logic        op    = 1'b0;
   logic [31:0] a_in  = '0;
   logic [31:0] b_in  = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_by_zero;

   int          cyc     = 0;
   int          n_cmp   = 0;
   int          n_err   = 0;
   logic [31:0] held_hi = '0;
   logic [31:0] held_lo = '0;
   exp_t        scoreboard[$];
   exp_t        mon_e;

   muldiv_sequencer #(.WIDTH(32), .MUL_WAIT(MUL_WAIT)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .op          (op),
      .a_in        (a_in),
      .b_in        (b_in),
      .busy        (busy),
      .done        (done),
      .hi_out      (hi_out),
      .lo_out      (lo_out),
      .div_by_zero (div_by_zero)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain 64-bit signed arithmetic; SV / and % truncate toward zero.
   function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                  input int s);
      exp_t        e;
      longint      sa, sbv, p, q, r;
      logic [63:0] w;
      int          lat;
      sa    = longint'($signed(a));
      sbv   = longint'($signed(b));
      e.dbz = 1'b0;
      if (o == 1'b0) begin
         p    = sa * sbv;
         w    = p;
         e.hi = w[63:32];
         e.lo = w[31:0];
         lat  = MUL_WAIT + 1;
`ifdef MULDIV_EARLY_OUT_EN
         if (a == 0 || b == 0) lat = 1;
`endif
      end else if (b == 0) begin
         e.hi  = a;
         e.lo  = 32'hFFFF_FFFF;
         e.dbz = 1'b1;
         lat   = 1;
      end else begin
         q    = sa / sbv;
         r    = sa % sbv;
         w    = q;
         e.lo = w[31:0];
         w    = r;
         e.hi = w[31:0];
         lat  = DIV_LAT;
`ifdef MULDIV_EARLY_OUT_EN
         if ((sa < 0 ? -sa : sa) < (sbv < 0 ? -sbv : sbv)) lat = 1;
`endif
      end
      e.cyc = s + lat;
      return e;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = '0;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h8000_0000;
         3: begin
            v = $urandom_range(1, 20);
            if ($urandom_range(0, 1) == 1) v = -v;
         end
         default: v = $urandom();
      endcase
      return v;
   endfunction

   // Advance n cycles, leaving the bench 1 time unit after the rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Drive start for one cycle; optionally push the expected result.
   task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b, input bit push);
      exp_t e;
      int   s;
      s = cyc;
      e = model(o, a, b, s);
      if (push) scoreboard.push_back(e);
      op    = o;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      step(1);
      start = 1'b0;
      if (e.cyc - s > 1) begin
         check("busy_after_start", busy, 1);
         check("dbz_cleared_on_start", div_by_zero, 0);
      end
   endtask

   task automatic wait_done();
      for (int k = 0; k < 200 && scoreboard.size() != 0; k++) step(1);
      if (scoreboard.size() != 0) begin
         check("done_timeout_pending", scoreboard.size(), 0);
         scoreboard.delete();
      end
   endtask

   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b);
      issue(o, a, b, 1'b1);
      wait_done();
   endtask

   // Monitor: hold check while busy, scoreboard compare on every done pulse.
   always @(negedge clock) begin
      if (!clear) begin
         if (busy) begin
            check("hold_hi", hi_out, held_hi);
            check("hold_lo", lo_out, held_lo);
         end
         if (done) begin
            if (scoreboard.size() == 0) begin
               check("unexpected_done", done, 0);
            end else begin
               mon_e = scoreboard.pop_front();
               check("done_cycle", cyc, mon_e.cyc);
               check("hi", hi_out, mon_e.hi);
               check("lo", lo_out, mon_e.lo);
               check("div_by_zero", div_by_zero, mon_e.dbz);
               check("busy_at_done", busy, 0);
               held_hi = mon_e.hi;
               held_lo = mon_e.lo;
            end
         end
      end
   end

   initial begin
      step(3);
      clear = 1'b0;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_hi", hi_out, 0);
      check("reset_lo", lo_out, 0);
      check("reset_dbz", div_by_zero, 0);

      // Directed cases.
      run_op(1'b0, 32'd7, 32'hFFFF_FFFD);
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000);
      run_op(1'b1, -32'sd7, 32'd2);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(1'b1, 32'd5, 32'd0);
      run_op(1'b0, 32'd3, 32'd4);
      run_op(1'b1, 32'd3, 32'd10);
`ifdef MULDIV_EARLY_OUT_EN
      run_op(1'b0, 32'd0, 32'd123);
`endif

      // Start pulses in cycles 5 and 20 of a DIV must be ignored.
      step(1);
      issue(1'b1, 32'd1000, -32'sd33, 1'b1);
      step(4);
      op = 1'b0; a_in = 32'd11; b_in = 32'd13; start = 1'b1;
      step(1);
      start = 1'b0;
      step(14);
      op = 1'b1; a_in = 32'd50; b_in = 32'd0; start = 1'b1;
      step(1);
      start = 1'b0;
      wait_done();
      step(3);

      // Start during the DONE cycle must be ignored.
      issue(1'b0, 32'd21, 32'd2, 1'b1);
      step(MUL_WAIT);
      op = 1'b1; a_in = 32'd9; b_in = 32'd0; start = 1'b1;
      step(1);
      start = 1'b0;
      wait_done();
      step(10);
      check("dbz_after_ignored_start", div_by_zero, 0);

      // clear in cycle 10 of a DIV: no done, results zeroed next cycle.
      run_op(1'b0, 32'h1234, 32'h5678);
      issue(1'b1, 32'd100, 32'd7, 1'b0);
      step(9);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      check("clear_busy", busy, 0);
      check("clear_done", done, 0);
      check("clear_hi", hi_out, 0);
      check("clear_lo", lo_out, 0);
      check("clear_dbz", div_by_zero, 0);
      held_hi = '0;
      held_lo = '0;
      step(40);

      // Randomized mix, including back-to-back starts one cycle after done.
      repeat (40) begin
         run_op(1'($urandom_range(0, 1)), pick(), pick());
         step($urandom_range(0, 2));
      end

      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
